// File: rtl/sar_search_4bit.sv
// sar_search_4bit: MSB-first successive-approximation search driving a magnitude
// comparator's b input and consuming its equal/greater/less flags.
module sar_search_4bit #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    input  logic             cmp_less,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_TRIAL, S_DONE} state_t;
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_bit, w_bit;
    logic [WIDTH-1:0] r_guess, w_guess;
    logic [WIDTH-1:0] r_partial, w_partial;
    logic [WIDTH-1:0] r_result, w_result;
    logic [2:0]       r_cnt, w_cnt;
    logic             r_found, w_found;
    logic             r_err, w_err;
    logic             w_eq, w_gt, w_lt;
    logic [WIDTH-1:0] w_part_upd;
    assign w_eq = cmp_equal & ~cmp_greater & ~cmp_less;
    assign w_gt = ~cmp_equal & cmp_greater & ~cmp_less;
    assign w_lt = ~cmp_equal & ~cmp_greater & cmp_less;
    // The guess is partial with the trial bit set, so "keep the bit" is just the guess.
    assign w_part_upd = w_gt ? r_guess : r_partial;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit     <= '0;
            r_guess   <= '0;
            r_partial <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_found   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit     <= w_bit;
            r_guess   <= w_guess;
            r_partial <= w_partial;
            r_result  <= w_result;
            r_cnt     <= w_cnt;
            r_found   <= w_found;
            r_err     <= w_err;
        end
    end
    always_comb begin
        w_state   = r_state;
        w_bit     = r_bit;
        w_guess   = r_guess;
        w_partial = r_partial;
        w_result  = r_result;
        w_cnt     = r_cnt;
        w_found   = r_found;
        w_err     = r_err;
        case (r_state)
            S_IDLE: if (start) begin
                w_state   = S_TRIAL;
                w_bit     = MSB;
                w_guess   = MSB;
                w_partial = '0;
                w_cnt     = '0;
                w_found   = 1'b0;
                w_err     = 1'b0;
            end
            S_TRIAL: if (r_cnt < 3'(SETTLE)) begin
                w_cnt = r_cnt + 3'd1;
            end else if (w_eq) begin
                w_result = r_guess;
                w_found  = 1'b1;
                w_state  = S_DONE;
            end else if (w_gt | w_lt) begin
                w_partial = w_part_upd;
                if (r_bit[0]) begin
                    w_result = w_part_upd;
                    w_state  = S_DONE;
                end else begin
                    w_bit   = r_bit >> 1;
                    w_guess = w_part_upd | (r_bit >> 1);
                    w_cnt   = '0;
                end
            end else begin
                w_result = r_partial;
                w_err    = 1'b1;
                w_state  = S_DONE;
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end
    assign guess  = r_guess;
    assign busy   = (r_state == S_TRIAL);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;
endmodule
